// File: rtl/hash_msg_feeder_pkg.sv
// Shared types for the hash message feeder: FSM state codes and the byte FIFO entry.
package hash_feeder_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_ARM    = 3'd2;
    localparam state_t S_OFFER  = 3'd3;
    localparam state_t S_DISARM = 3'd4;
    localparam state_t S_STALL  = 3'd5;
    localparam state_t S_EOF    = 3'd6;
    localparam state_t S_WAIT_H = 3'd7;

    typedef struct packed {
        logic       last;
        logic       keep;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/hash_msg_feeder_if.sv
// Host byte stream, hash-core byte handshake and status, bundled for the feeder.
interface hash_msg_feeder_if #(
    parameter int LEN_W = 16
) ();
    logic             host_valid;
    logic [7:0]       host_data;
    logic             host_last;
    logic             host_keep;
    logic             host_ready;
    logic             start;
    logic             F_dr;
    logic [7:0]       M_data;
    logic             F_rtr;
    logic             End_of_File;
    logic             H_ready;
    logic             busy;
    logic             msg_done;
    logic [LEN_W-1:0] msg_len;
    logic             len_ovf;

    // master = the feeder itself
    modport master (
        input  host_valid, host_data, host_last, host_keep, F_rtr, H_ready,
        output host_ready, start, F_dr, M_data, End_of_File, busy, msg_done, msg_len, len_ovf
    );

    modport slave (
        output host_valid, host_data, host_last, host_keep, F_rtr, H_ready,
        input  host_ready, start, F_dr, M_data, End_of_File, busy, msg_done, msg_len, len_ovf
    );
endinterface

// File: rtl/hash_msg_feeder_byte_fifo.sv
// Synchronous first-word-fall-through FIFO of message bytes with keep/last tags.
module byte_fifo
    import hash_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  fifo_entry_t wr_data,
    input  logic        rd_en,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    fifo_entry_t    mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_wr;
    logic           do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/hash_msg_feeder.sv
// Feeds buffered host bytes to the hash core over F_dr/F_rtr, then signals EOF and waits for the digest.
module hash_msg_feeder
    import hash_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hash_msg_feeder_if.master bus
);
    state_t           state;
    state_t           state_nxt;
    fifo_entry_t      wr_entry;
    fifo_entry_t      head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             xfer;
    logic             arm_go;
    logic             ready_q;
    logic             pend_eof;
    logic             eof_seen;
    logic             msg_done_q;
    logic [7:0]       m_data_q;
    logic [LEN_W-1:0] msg_len_q;
    logic             len_ovf_q;

    assign xfer          = (state == S_OFFER) && bus.F_rtr;
    assign arm_go        = (state == S_ARM) && bus.F_rtr && !empty;
    assign pop           = xfer || (arm_go && !head.keep);
    assign bus.host_ready = ready_q && (!full || pop);
    assign push          = bus.host_valid && bus.host_ready;
    assign wr_entry      = '{last: bus.host_last, keep: bus.host_keep, data: bus.host_data};

    byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!empty) state_nxt = S_START;
            S_START:  state_nxt = S_ARM;
            S_ARM:    if (arm_go) state_nxt = head.keep ? S_OFFER : S_EOF;
            S_OFFER:  if (xfer) state_nxt = S_DISARM;
            // The core lowers F_rtr a cycle late, so wait to see it low before re-arming.
            S_DISARM: if (!bus.F_rtr) state_nxt = pend_eof ? S_EOF : (empty ? S_STALL : S_ARM);
            S_STALL:  if (!empty) state_nxt = S_ARM;
            S_EOF:    if (eof_seen && !bus.F_rtr) state_nxt = S_WAIT_H;
            S_WAIT_H: if (bus.H_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ready_q    <= 1'b0;
            pend_eof   <= 1'b0;
            eof_seen   <= 1'b0;
            msg_done_q <= 1'b0;
            m_data_q   <= '0;
            msg_len_q  <= '0;
            len_ovf_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ready_q    <= 1'b1;
            msg_done_q <= (state == S_WAIT_H) && bus.H_ready;
            eof_seen   <= (state == S_EOF) && (eof_seen || bus.F_rtr);
            if (state == S_START) begin
                msg_len_q <= '0;
                len_ovf_q <= 1'b0;
                pend_eof  <= 1'b0;
            end
            if (arm_go && head.keep) m_data_q <= head.data;
            if (xfer) begin
                pend_eof <= head.last;
                if (&msg_len_q) len_ovf_q <= 1'b1;
                else            msg_len_q <= msg_len_q + 1'b1;
            end
        end
    end

    assign bus.start       = (state == S_START);
    assign bus.F_dr        = xfer;
    assign bus.M_data      = m_data_q;
    assign bus.End_of_File = (state == S_EOF);
    assign bus.busy        = (state != S_IDLE);
    assign bus.msg_done    = msg_done_q;
    assign bus.msg_len     = msg_len_q;
    assign bus.len_ovf     = len_ovf_q;
endmodule

// File: tb/tb_hash_msg_feeder.sv
// Scoreboard bench: host stimulus pushes expected bytes/lengths; a core model + monitor pops and compares.
module tb_hash_msg_feeder;
    localparam int DEPTH  = 16;
    localparam int LW     = 4;
    localparam int MAXLEN = (1 << LW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hash_msg_feeder_if #(.LEN_W(LW)) bus ();

    hash_msg_feeder #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    int         len_q[$];

    int fixed_low = 0;
    bit in_msg, post_start, eof_checked, hr_seen, got_eof, hold_pending, dropping;
    bit full_win, saw_full;
    int cur_cnt, hr_cyc, cyc, low_cnt, h_cnt, viol;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_ready"}, bus.host_ready, 0);
        check({tag, "_start"}, bus.start, 0);
        check({tag, "_F_dr"}, bus.F_dr, 0);
        check({tag, "_M_data"}, bus.M_data, 0);
        check({tag, "_End_of_File"}, bus.End_of_File, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_msg_done"}, bus.msg_done, 0);
        check({tag, "_msg_len"}, bus.msg_len, 0);
        check({tag, "_len_ovf"}, bus.len_ovf, 0);
    endtask

    // Hash core model and output monitor: F_rtr held low for a while, raised, and dropped one cycle
    // after each accepted byte or EOF; H_ready raised a few cycles after EOF completes.
    initial begin
        int e;
        bus.F_rtr   = 1'b0;
        bus.H_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.F_rtr = 1'b0; bus.H_ready = 1'b0;
                got_eof = 0; hold_pending = 0; dropping = 0; low_cnt = 0; h_cnt = 0;
                in_msg = 0; post_start = 0; hr_seen = 0; eof_checked = 0; cur_cnt = 0;
            end else begin
                if (hold_pending) begin
                    hold_pending = 0;
                    dropping     = 1;
                end else if (dropping) begin
                    dropping  = 0;
                    bus.F_rtr = 1'b0;
                    low_cnt   = (fixed_low > 0) ? fixed_low : $urandom_range(1, 6);
                end else if (!bus.F_rtr && !got_eof) begin
                    if (low_cnt > 0) low_cnt--;
                    else bus.F_rtr = 1'b1;
                end
                if (got_eof && !bus.F_rtr && !dropping && !bus.H_ready) begin
                    h_cnt++;
                    if (h_cnt >= 4) bus.H_ready = 1'b1;
                end
            end
            #1;
            if (rst_n) begin
                cyc++;
                if (bus.F_dr && !bus.F_rtr) viol++;
                if (full_win && !bus.host_ready) saw_full = 1;
                if (bus.start) begin
                    check("start_only_after_done", in_msg, 0);
                    in_msg = 1; post_start = 1; cur_cnt = 0; eof_checked = 0; hr_seen = 0;
                    got_eof = 0; h_cnt = 0; bus.H_ready = 1'b0;
                end else if (post_start) begin
                    post_start = 0;
                    check("len_cleared_at_start", bus.msg_len, 0);
                    check("ovf_cleared_at_start", bus.len_ovf, 0);
                end
                if (bus.F_dr && bus.F_rtr) begin
                    hold_pending = 1;
                    if (exp_q.size() == 0) check("byte_expected", exp_q.size(), 1);
                    else check("byte_value", bus.M_data, exp_q.pop_front());
                    cur_cnt++;
                end
                if (bus.End_of_File && !eof_checked) begin
                    eof_checked = 1;
                    check("eof_byte_count", cur_cnt, (len_q.size() > 0) ? len_q[0] : -1);
                end
                if (bus.End_of_File && bus.F_rtr && !got_eof) begin
                    got_eof      = 1;
                    hold_pending = 1;
                end
                if (bus.H_ready && !hr_seen) begin
                    hr_seen = 1;
                    hr_cyc  = cyc;
                end
                if (bus.msg_done) begin
                    e = (len_q.size() > 0) ? len_q.pop_front() : -1;
                    check("done_one_cycle_after_hready", cyc - hr_cyc, 1);
                    check("msg_len", bus.msg_len, (e > MAXLEN) ? MAXLEN : e);
                    check("len_ovf", bus.len_ovf, (e > MAXLEN) ? 1 : 0);
                    in_msg = 0;
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input bit keep, input bit last);
        int t;
        @(negedge clk);
        bus.host_valid = 1'b1;
        bus.host_data  = d;
        bus.host_keep  = keep;
        bus.host_last  = last;
        t = 0;
        #1;
        while (!bus.host_ready && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 2000) check("host_accept_timeout", bus.host_ready, 1);
    endtask

    task automatic host_idle();
        @(negedge clk);
        bus.host_valid = 1'b0;
    endtask

    task automatic send_msg(input int n, input bit empty_tail);
        logic [7:0] d;
        len_q.push_back(n);
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_beat(d, 1'b1, (i == n - 1) && !empty_tail);
        end
        if (n == 0 || empty_tail) send_beat(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((len_q.size() != 0 || in_msg) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("all_messages_completed", len_q.size(), 0);
        check("all_bytes_delivered", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] abc [3];
        int         t;
        abc[0] = 8'h61; abc[1] = 8'h62; abc[2] = 8'h63;
        bus.host_valid = 1'b0;
        bus.host_data  = '0;
        bus.host_keep  = 1'b0;
        bus.host_last  = 1'b0;

        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("host_ready_after_reset", bus.host_ready, 1);
        check("idle_after_reset", bus.busy, 0);

        // "abc" with a slow core
        fixed_low = 14;
        len_q.push_back(3);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(abc[i]);
            send_beat(abc[i], 1'b1, i == 2);
        end
        host_idle();
        wait_done();

        // empty message
        fixed_low = 0;
        send_msg(0, 1'b0);
        host_idle();
        wait_done();

        // host pauses between bytes 2 and 3
        fixed_low = 2;
        len_q.push_back(3);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'(8'h30 + i));
            send_beat(8'(8'h30 + i), 1'b1, 1'b0);
        end
        host_idle();
        repeat (20) @(negedge clk);
        #2;
        check("stall_busy", bus.busy, 1);
        check("stall_F_dr", bus.F_dr, 0);
        check("stall_End_of_File", bus.End_of_File, 0);
        exp_q.push_back(8'h32);
        send_beat(8'h32, 1'b1, 1'b1);
        host_idle();
        wait_done();
        fixed_low = 0;

        // fill the FIFO with one message and queue a second behind it
        full_win = 1;
        send_msg(16, 1'b0);
        send_msg(5, 1'b0);
        host_idle();
        full_win = 0;
        check("fifo_reached_full", saw_full, 1);
        wait_done();

        // length saturation
        send_msg(20, 1'b0);
        host_idle();
        wait_done();

        // reset while the third of five bytes is on offer
        fixed_low = 3;
        send_msg(5, 1'b0);
        host_idle();
        t = 0;
        while (!(cur_cnt == 3 && bus.F_dr && bus.F_rtr) && t < 2000) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("reached_third_offer", cur_cnt, 3);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        len_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check("fifo_flushed_idle", bus.busy, 0);
        check("host_ready_after_mid_reset", bus.host_ready, 1);
        fixed_low = 0;
        send_msg(3, 1'b0);
        host_idle();
        wait_done();

        // random messages, some with an empty tail beat
        for (int k = 0; k < 6; k++) send_msg($urandom_range(0, 7), 1'($urandom_range(0, 1)));
        host_idle();
        wait_done();

        check("F_dr_never_without_F_rtr", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
